prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream stage of the CPU/RAM subsystem. Receives a byte-serial program frame, assembles 16-bit instruction words and writes them into the program RAM's single write port.
- Holds the CPU in reset (cpu_rst_n low) for the whole load. Releases it with the frame's start_pc only after the checksum passes.
- Replaces hand-initialised RAM contents for bring-up and test.

Parameters:
- BASE_ADDR, 8'h00, RAM word address that receives the first instruction word.
- RELEASE_DLY, 2, cycles between a checksum pass and cpu_rst_n rising (1..15).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte this cycle.
- ram_w_en  out  1  RAM write enable, one-cycle pulse per word.
- ram_addr  out  8  RAM write address.
- ram_w_data  out  16  RAM write data.
- start_pc  out  8  PC value presented to the CPU, registered.
- cpu_rst_n  out  1  CPU reset, active-low; low until release.
- done  out  1  load complete and CPU released.
- error  out  1  checksum mismatch, sticky.

Behaviour:
- Reset values (cycle after rst=1):
  - in_ready=1, ram_w_en=0, ram_addr=BASE_ADDR, ram_w_data=0, start_pc=0.
  - cpu_rst_n=0, done=0, error=0.
  - state=S_PC, word counter=0, checksum accumulator=0.
- rst dominates every other input. Reset mid-load abandons the frame; any RAM words already written are not rolled back.
- Handshake: a byte is accepted on a posedge where in_valid && in_ready. in_data is ignored when in_ready=0. in_ready depends only on state, never combinationally on in_valid.
- Frame format, in order:
  - PC byte.
  - CNT byte (word count N, 0..255).
  - N words, each sent high byte then low byte.
  - CHK byte.
- Checksum: CHK must equal the XOR of every preceding frame byte (PC, CNT and all data bytes).
- States and transitions:
  - S_PC: accept byte -> latch into start_pc reg, acc=byte -> S_CNT.
  - S_CNT: accept -> cnt=byte, acc^=byte. Go to S_CHK if byte==0, else S_HI.
  - S_HI: accept -> hold byte as high half, acc^=byte -> S_LO.
  - S_LO: accept -> acc^=byte.
    - Next cycle: ram_w_en=1, ram_w_data={hi,byte}, ram_addr=BASE_ADDR+word_idx.
    - word_idx increments after the write.
    - If word_idx+1==cnt go to S_CHK, else S_HI.
  - S_CHK: accept -> compare byte with acc. Equal -> S_WAIT; unequal -> S_ERR.
  - S_WAIT: in_ready=0. Count RELEASE_DLY cycles, then cpu_rst_n=1, done=1 -> S_RUN.
  - S_RUN: in_ready=0, cpu_rst_n=1, done=1. Stays here until rst.
  - S_ERR: in_ready=0, error=1, cpu_rst_n=0, done=0. Stays here until rst.
- Write latency: exactly 1 cycle from the low-byte handshake edge to ram_w_en high. ram_w_en never high for two consecutive cycles.
- Back-to-back bytes are accepted every cycle; the loader never stalls in S_PC..S_CHK.
- ram_addr is 8 bits and wraps mod 256: BASE_ADDR=8'hFE with N=3 writes FE, FF, 00.
- start_pc is stable from the PC byte onward. The CPU samples it while cpu_rst_n=0, so it is valid before release.
- ram_addr holds the last written address when ram_w_en=0.

Test Plan:
- Normal load, BASE_ADDR=0, RELEASE_DLY=2:
  - Stimulus: stream 05,02,D1,07,E0,00,chk=05^02^D1^07^E0^00=31.
  - Required: writes [00]=D107 and [01]=E000, each 1 cycle after its low byte.
  - Required: cpu_rst_n rises 2 cycles after CHK is accepted; start_pc=05; done=1; in_ready=0.
- Bad checksum: same frame with chk=30 -> error=1, cpu_rst_n stays 0, done=0, in_ready=0 until rst.
- Empty program: stream 10,00,10 -> no ram_w_en pulse, start_pc=10, release after RELEASE_DLY.
- Gapped input: same frame as the normal load with in_valid low for 3 cycles between every byte -> identical writes and result. Bytes presented with in_valid=0 are ignored.
- Address wrap, BASE_ADDR=FE: frame 00,03 followed by three words -> writes land at FE, FF, 00.
- Reset mid-load: assert rst after the first word's high byte.
  - Required: next cycle every output is at its reset value, state=S_PC.
  - Required: a full new frame then loads correctly and the partial word is never written.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-RAM write port of the program loader.
// The loader sits on the slave modport; whoever feeds it uses master.
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ram_w_en;
  logic [7:0]  ram_addr;
  logic [15:0] ram_w_data;
  logic [7:0]  start_pc;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  modport slave (
    input  in_valid, in_data,
    output in_ready, ram_w_en, ram_addr, ram_w_data, start_pc, cpu_rst_n, done, error
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, ram_w_en, ram_addr, ram_w_data, start_pc, cpu_rst_n, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a byte-serial program frame (PC, CNT, N words, CHK) into program RAM and
// releases the CPU from reset once the XOR checksum matches.
module prog_loader #(
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned RELEASE_DLY = 2
) (
  input logic          clk,
  input logic          rst,
  prog_loader_if.slave bus
);

  typedef enum logic [2:0] {StPc, StCnt, StHi, StLo, StChk, StWait, StRun, StErr} state_e;

  localparam logic [3:0] DlyLast = 4'(RELEASE_DLY - 1);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [3:0]  dly_q, dly_d;
  logic        ready;
  logic        accept;

  // Ready is a pure function of state so it never loops back through in_valid.
  assign ready  = (state_q == StPc) || (state_q == StCnt) || (state_q == StHi) ||
                  (state_q == StLo) || (state_q == StChk);
  assign accept = bus.in_valid && ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    dly_d   = dly_q;
    unique case (state_q)
      StPc: if (accept) begin
        pc_d    = bus.in_data;
        acc_d   = bus.in_data;
        state_d = StCnt;
      end
      StCnt: if (accept) begin
        cnt_d   = bus.in_data;
        acc_d   = acc_q ^ bus.in_data;
        state_d = (bus.in_data == 8'h00) ? StChk : StHi;
      end
      StHi: if (accept) begin
        hi_d    = bus.in_data;
        acc_d   = acc_q ^ bus.in_data;
        state_d = StLo;
      end
      StLo: if (accept) begin
        acc_d   = acc_q ^ bus.in_data;
        wen_d   = 1'b1;
        wdata_d = {hi_q, bus.in_data};
        addr_d  = BASE_ADDR + idx_q;
        idx_d   = idx_q + 8'd1;
        state_d = ((idx_q + 8'd1) == cnt_q) ? StChk : StHi;
      end
      StChk: if (accept) begin
        dly_d   = '0;
        state_d = (bus.in_data == acc_q) ? StWait : StErr;
      end
      StWait: begin
        if (dly_q == DlyLast) begin
          state_d = StRun;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      StRun: state_d = StRun;
      StErr: state_d = StErr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StPc;
      pc_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      dly_q   <= dly_d;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.ram_w_en   = wen_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_w_data = wdata_q;
  assign bus.start_pc   = pc_q;
  assign bus.cpu_rst_n  = (state_q == StRun);
  assign bus.done       = (state_q == StRun);
  assign bus.error      = (state_q == StErr);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 00 and FE) see the same byte stream and
// are checked cycle by cycle against a frame-level model of writes and release timing.
module tb_prog_loader;

  localparam int RelDly = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if bus0 ();
  prog_loader_if bus1 ();

  prog_loader #(.BASE_ADDR(8'h00), .RELEASE_DLY(RelDly)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  prog_loader #(.BASE_ADDR(8'hFE), .RELEASE_DLY(RelDly)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int          total = 0;
  int          bad   = 0;
  int          pend  = -1;
  logic [7:0]  exp_a0, exp_a1;
  logic [7:0]  frame[$];
  logic [15:0] words[$];

  task automatic set_in(input logic v, input logic [7:0] d);
    bus0.in_valid = v;
    bus0.in_data  = d;
    bus1.in_valid = v;
    bus1.in_data  = d;
  endtask

  // Build frame from pc and the words queue; a nonzero flip corrupts the checksum.
  task automatic make_frame(input logic [7:0] pc, input logic [7:0] flip);
    logic [7:0] chk;
    frame = {};
    frame.push_back(pc);
    frame.push_back(8'(words.size()));
    foreach (words[i]) begin
      frame.push_back(words[i][15:8]);
      frame.push_back(words[i][7:0]);
    end
    chk = 8'h00;
    foreach (frame[i]) chk = chk ^ frame[i];
    frame.push_back(chk ^ flip);
  endtask

  // One cycle of stimulus; checks ready and the RAM port at the following negedge.
  task automatic drive_byte(input logic v, input logic [7:0] d, input logic rdy_exp);
    logic wen_exp;
    set_in(v, d);
    @(negedge clk);
    wen_exp = (pend >= 0);
    if (wen_exp) begin
      exp_a0 = 8'h00 + pend[7:0];
      exp_a1 = 8'hFE + pend[7:0];
    end
    total++;
    if (bus0.in_ready !== rdy_exp || bus1.in_ready !== rdy_exp) begin
      bad++;
      $display("FAIL in_ready: got %b/%b want %b", bus0.in_ready, bus1.in_ready, rdy_exp);
    end
    total++;
    if (bus0.ram_w_en !== wen_exp || bus0.ram_addr !== exp_a0) begin
      bad++;
      $display("FAIL wr_port0: got en=%b addr=%h want en=%b addr=%h",
               bus0.ram_w_en, bus0.ram_addr, wen_exp, exp_a0);
    end
    total++;
    if (bus1.ram_w_en !== wen_exp || bus1.ram_addr !== exp_a1) begin
      bad++;
      $display("FAIL wr_port1: got en=%b addr=%h want en=%b addr=%h",
               bus1.ram_w_en, bus1.ram_addr, wen_exp, exp_a1);
    end
    if (wen_exp) begin
      total++;
      if (bus0.ram_w_data !== words[pend] || bus1.ram_w_data !== words[pend]) begin
        bad++;
        $display("FAIL wr_data: got %h/%h want %h", bus0.ram_w_data, bus1.ram_w_data,
                 words[pend]);
      end
    end
    @(posedge clk);
    #1;
    pend = -1;
  endtask

  task automatic drive_frame(input int gap);
    int g;
    for (int k = 0; k < frame.size(); k++) begin
      drive_byte(1'b1, frame[k], 1'b1);
      if (k >= 3 && (k % 2) == 1 && k < frame.size() - 1) pend = (k - 3) / 2;
      if (k < frame.size() - 1) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        for (int j = 0; j < g; j++) drive_byte(1'b0, 8'($urandom), 1'b1);
      end
    end
  endtask

  // After CHK: valid bytes keep arriving and must be ignored while release is timed.
  task automatic check_outcome(input logic good, input logic [7:0] pc);
    logic rel;
    for (int c = 0; c <= RelDly + 1; c++) begin
      set_in(1'b1, 8'($urandom));
      @(negedge clk);
      rel = good && (c >= RelDly);
      total++;
      if (bus0.in_ready !== 1'b0 || bus0.cpu_rst_n !== rel || bus0.done !== rel ||
          bus0.error !== !good || bus0.start_pc !== pc || bus0.ram_w_en !== 1'b0) begin
        bad++;
        $display("FAIL outcome0 c=%0d: rdy=%b rn=%b dn=%b er=%b pc=%h wen=%b want 0 %b %b %b %h 0",
                 c, bus0.in_ready, bus0.cpu_rst_n, bus0.done, bus0.error, bus0.start_pc,
                 bus0.ram_w_en, rel, rel, !good, pc);
      end
      total++;
      if (bus1.in_ready !== 1'b0 || bus1.cpu_rst_n !== rel || bus1.done !== rel ||
          bus1.error !== !good || bus1.start_pc !== pc || bus1.ram_w_en !== 1'b0) begin
        bad++;
        $display("FAIL outcome1 c=%0d: rdy=%b rn=%b dn=%b er=%b pc=%h wen=%b want 0 %b %b %b %h 0",
                 c, bus1.in_ready, bus1.cpu_rst_n, bus1.done, bus1.error, bus1.start_pc,
                 bus1.ram_w_en, rel, rel, !good, pc);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b1, 8'($urandom));
    pend = -1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(1'b0, 8'($urandom));
    exp_a0 = 8'h00;
    exp_a1 = 8'hFE;
    @(negedge clk);
    total++;
    if (bus0.in_ready !== 1'b1 || bus0.ram_w_en !== 1'b0 || bus0.ram_addr !== 8'h00 ||
        bus0.ram_w_data !== 16'h0000 || bus0.start_pc !== 8'h00 || bus0.cpu_rst_n !== 1'b0 ||
        bus0.done !== 1'b0 || bus0.error !== 1'b0) begin
      bad++;
      $display("FAIL reset0: rdy=%b wen=%b addr=%h wd=%h pc=%h rn=%b dn=%b er=%b want 1 0 00 0000 00 0 0 0",
               bus0.in_ready, bus0.ram_w_en, bus0.ram_addr, bus0.ram_w_data, bus0.start_pc,
               bus0.cpu_rst_n, bus0.done, bus0.error);
    end
    total++;
    if (bus1.in_ready !== 1'b1 || bus1.ram_w_en !== 1'b0 || bus1.ram_addr !== 8'hFE ||
        bus1.ram_w_data !== 16'h0000 || bus1.start_pc !== 8'h00 || bus1.cpu_rst_n !== 1'b0 ||
        bus1.done !== 1'b0 || bus1.error !== 1'b0) begin
      bad++;
      $display("FAIL reset1: rdy=%b wen=%b addr=%h wd=%h pc=%h rn=%b dn=%b er=%b want 1 0 fe 0000 00 0 0 0",
               bus1.in_ready, bus1.ram_w_en, bus1.ram_addr, bus1.ram_w_data, bus1.start_pc,
               bus1.cpu_rst_n, bus1.done, bus1.error);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_normal();
    test_reset();
    words = '{16'hD107, 16'hE000};
    make_frame(8'h05, 8'h00);
    drive_frame(0);
    check_outcome(1'b1, 8'h05);
  endtask

  task automatic test_bad_chk();
    test_reset();
    words = '{16'hD107, 16'hE000};
    make_frame(8'h05, 8'h01);
    drive_frame(0);
    check_outcome(1'b0, 8'h05);
  endtask

  task automatic test_empty();
    test_reset();
    words = {};
    make_frame(8'h10, 8'h00);
    drive_frame(0);
    check_outcome(1'b1, 8'h10);
  endtask

  task automatic test_gapped();
    test_reset();
    words = '{16'hD107, 16'hE000};
    make_frame(8'h05, 8'h00);
    drive_frame(3);
    check_outcome(1'b1, 8'h05);
  endtask

  task automatic test_wrap();
    test_reset();
    words = {};
    for (int i = 0; i < 3; i++) words.push_back(16'($urandom));
    make_frame(8'h00, 8'h00);
    drive_frame(0);
    check_outcome(1'b1, 8'h00);
  endtask

  // Abandon a frame right after the first high byte, then load a fresh one.
  task automatic test_reset_mid();
    logic [7:0] pc;
    test_reset();
    words = '{16'hD107, 16'hE000};
    make_frame(8'h05, 8'h00);
    for (int k = 0; k < 3; k++) drive_byte(1'b1, frame[k], 1'b1);
    test_reset();
    pc = 8'($urandom);
    words = {};
    for (int i = 0; i < 3; i++) words.push_back(16'($urandom));
    make_frame(pc, 8'h00);
    drive_frame(0);
    check_outcome(1'b1, pc);
  endtask

  task automatic test_random();
    logic [7:0] pc;
    logic [7:0] flip;
    int         n;
    for (int it = 0; it < 6; it++) begin
      test_reset();
      pc   = 8'($urandom);
      n    = $urandom_range(0, 6);
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      words = {};
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      make_frame(pc, flip);
      drive_frame(-1);
      check_outcome(flip == 8'h00, pc);
    end
  endtask

  initial begin
    set_in(1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_normal();
    test_bad_chk();
    test_empty();
    test_gapped();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
